pwm_duty_meter: RTL and testbench

Measures an external PWM waveform. Reports its period, high time and duty cycle in percent, sampled in the system clock domain. It is the receive-side counterpart of the breathing-LED PWM generators and lets the board loop a PWM output back and check it. Typical consumers are the two-digit segment display or a self-test.

---
 rtl/pwm_duty_meter.sv | 149 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures period, high time and integer duty percentage of an
// asynchronous PWM input. Flags a lost signal and captures dropped while a divide is busy.
module pwm_duty_meter #(
  parameter int CNT_W   = 25,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             overrun
);

  localparam int               REM_W = CNT_W + 7;
  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t             state;
  logic               s1, s2, d;
  logic [CNT_W-1:0]   cnt, hi;
  logic [CNT_W-1:0]   p_cap, h_cap;
  logic [REM_W-1:0]   rem;
  logic [6:0]         q;
  logic [2:0]         it;

  logic               rise;
  logic               timeout_hit;
  logic               do_report;
  logic               take_bit;
  logic [REM_W-1:0]   shifted;
  logic [REM_W-1:0]   rem_next;
  logic [6:0]         q_next;
  logic [CNT_W-1:0]   cnt_inc, hi_inc;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    rise        = s2 & ~d;
    cnt_inc     = (cnt == TO) ? cnt : cnt + CNT_W'(1);
    hi_inc      = (s2 && cnt != TO) ? hi + CNT_W'(1) : hi;
    // Fires on the edge where cnt would become TIMEOUT.
    timeout_hit = (cnt == TO_M1);
    do_report   = 1'b0;
    if (!rise && timeout_hit) begin
      if (state == MEASURE)                  do_report = 1'b1;
      else if (state == IDLE && !no_signal)  do_report = 1'b1;
    end
    shifted  = REM_W'(p_cap) << it;
    take_bit = (rem >= shifted);
    rem_next = take_bit ? rem - shifted : rem;
    q_next   = q | (7'(take_bit) << it);
  end

  // NOTE: all state is updated with non-blocking assignments; later assignments
  // in this block deliberately override earlier ones in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      d          <= 1'b0;
      cnt        <= '0;
      hi         <= '0;
      p_cap      <= '0;
      h_cap      <= '0;
      rem        <= '0;
      q          <= '0;
      it         <= '0;
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1         <= pwm_in;
      s2         <= s1;
      d          <= s2;
      meas_valid <= 1'b0;

      // Counters restart on every rise, whether it is captured or dropped.
      if (rise) begin
        cnt <= CNT_W'(1);
        hi  <= CNT_W'(1);
      end else begin
        cnt <= cnt_inc;
        hi  <= hi_inc;
      end

      case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            p_cap <= cnt;
            h_cap <= hi;
            rem   <= REM_W'(hi) * REM_W'(100);
            q     <= '0;
            it    <= 3'd6;
            state <= DIVIDE;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          q   <= q_next;
          it  <= it - 3'd1;
          if (it == 3'd0) begin
            period     <= p_cap;
            high_time  <= h_cap;
            duty_pct   <= q_next;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            if (rise) begin
              // Final iteration is free, so a rise here starts the next divide.
              p_cap <= cnt;
              h_cap <= hi;
              rem   <= REM_W'(hi) * REM_W'(100);
              q     <= '0;
              it    <= 3'd6;
            end else begin
              state <= MEASURE;
            end
          end else if (rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_report) begin
        period     <= '0;
        high_time  <= '0;
        duty_pct   <= s2 ? 7'd100 : 7'd0;
        meas_valid <= 1'b1;
        no_signal  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: clean PWM, latency, overrun, timeouts and
// reset during a division, with expected values worked out by hand.
module tb_pwm_duty_meter;

  localparam int CNT_W   = 25;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty_pct;
  logic             meas_valid, no_signal, overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int vcount     = 0;
  int last_v_cyc = 0;
  int last_gap   = 0;
  int v_period, v_high, v_duty, v_nosig;
  int first_rise_s;
  int vbase, s_edge, r_edge;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .duty_pct   (duty_pct),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records every pulse, sampled mid-cycle so the registered outputs are stable.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      vcount++;
      last_gap   = cyc - last_v_cyc;
      last_v_cyc = cyc;
      v_period   = int'(period);
      v_high     = int'(high_time);
      v_duty     = int'(duty_pct);
      v_nosig    = int'(no_signal);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pwm_cycles(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      if (k == 0) first_rise_s = cyc + 1;
      repeat (hi) step();
      pwm_in = 1'b0;
      repeat (per - hi) step();
    end
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (vcount < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(vcount >= target), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    check("rst_period",     32'(period),     32'd0);
    check("rst_high_time",  32'(high_time),  32'd0);
    check("rst_duty",       32'(duty_pct),   32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_no_signal",  32'(no_signal),  32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);

    // Clean 100/25: five rises give four measurements, 100 cycles apart.
    vbase = vcount;
    pwm_cycles(100, 25, 5);
    check("p100_count",   32'(vcount - vbase), 32'd4);
    check("p100_gap",     32'(last_gap),       32'd100);
    check("p100_period",  32'(v_period),       32'd100);
    check("p100_high",    32'(v_high),         32'd25);
    check("p100_duty",    32'(v_duty),         32'd25);
    check("p100_overrun", 32'(overrun),        32'd0);

    // Latency: capture of the previous period lands exactly 9 edges after S.
    pwm_cycles(12, 1, 1);
    check("latency_edge", 32'(last_v_cyc), 32'(first_rise_s + 9));
    pwm_cycles(100, 99, 1);
    check("p12_period", 32'(v_period), 32'd12);
    check("p12_high",   32'(v_high),   32'd1);
    check("p12_duty",   32'(v_duty),   32'd8);
    pwm_cycles(20, 10, 1);
    check("p100h99_period", 32'(v_period), 32'd100);
    check("p100h99_high",   32'(v_high),   32'd99);
    check("p100h99_duty",   32'(v_duty),   32'd99);

    // Period 5: every other rise is dropped while the divider is busy.
    vbase = vcount;
    pwm_cycles(5, 2, 10);
    repeat (20) step();
    check("p5_count",   32'(vcount - vbase), 32'd5);
    check("p5_gap",     32'(last_gap),       32'd10);
    check("p5_period",  32'(v_period),       32'd5);
    check("p5_high",    32'(v_high),         32'd2);
    check("p5_duty",    32'(v_duty),         32'd40);
    check("p5_overrun", 32'(overrun),        32'd1);

    // Stuck high after valid measurements: one timeout report.
    vbase = vcount;
    pwm_cycles(50, 20, 3);
    pwm_in = 1'b1;
    s_edge = cyc + 1;
    wait_pulses(vbase + 5, 1200, "hi_timeout_seen");
    check("hi_timeout_edge",   32'(last_v_cyc), 32'(s_edge + 2 + TIMEOUT - 1));
    check("hi_timeout_period", 32'(v_period),   32'd0);
    check("hi_timeout_high",   32'(v_high),     32'd0);
    check("hi_timeout_duty",   32'(v_duty),     32'd100);
    check("hi_timeout_nosig",  32'(v_nosig),    32'd1);
    repeat (1500) step();
    check("hi_timeout_single", 32'(vcount - vbase), 32'd5);

    // Two rises bring the meter back.
    pwm_in = 1'b0;
    repeat (10) step();
    vbase = vcount;
    pwm_cycles(40, 10, 2);
    check("recover_count",  32'(vcount - vbase), 32'd1);
    check("recover_nosig",  32'(no_signal),      32'd0);
    check("recover_period", 32'(v_period),       32'd40);
    check("recover_high",   32'(v_high),         32'd10);
    check("recover_duty",   32'(v_duty),         32'd25);

    // Reset three iterations into a divide aborts it silently.
    vbase  = vcount;
    pwm_in = 1'b1;
    repeat (6) step();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("abort_no_pulse", 32'(vcount - vbase), 32'd0);
    check("abort_period",   32'(period),         32'd0);
    check("abort_high",     32'(high_time),      32'd0);
    check("abort_duty",     32'(duty_pct),       32'd0);
    check("abort_nosig",    32'(no_signal),      32'd0);
    check("abort_overrun",  32'(overrun),        32'd0);
    pwm_cycles(30, 10, 1);
    check("abort_first_rise", 32'(vcount - vbase), 32'd0);
    pwm_cycles(30, 10, 1);
    check("abort_second_rise", 32'(vcount - vbase), 32'd1);
    check("abort_meas_period", 32'(v_period),       32'd30);
    check("abort_meas_high",   32'(v_high),         32'd10);
    check("abort_meas_duty",   32'(v_duty),         32'd33);

    // Stuck low from reset: exactly one report, TIMEOUT edges after reset.
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) step();
    rst    = 1'b0;
    r_edge = cyc;
    vbase  = vcount;
    wait_pulses(vbase + 1, 1200, "lo_timeout_seen");
    check("lo_timeout_edge",   32'(last_v_cyc), 32'(r_edge + TIMEOUT));
    check("lo_timeout_period", 32'(v_period),   32'd0);
    check("lo_timeout_duty",   32'(v_duty),     32'd0);
    check("lo_timeout_nosig",  32'(v_nosig),    32'd1);
    repeat (2000) step();
    check("lo_timeout_single", 32'(vcount - vbase), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
